fetch_unit: RTL and testbench

Parametrised instruction-fetch front end. It sits between instruction memory and the decoder. It prefetches sequential instructions into a DEPTH-entry queue, each entry tagged with its PC. When a control-transfer instruction is fetched, it stops fetching until the execute stage supplies the next PC; on that redirect it flushes the queue and any in-flight fetch.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 38 +++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: opcode constants, fetch FSM states and control-transfer decode shared by the fetch front end
package fetch_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_NOP = 7'b0010011;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} fetch_state_e;
  function automatic logic is_ctl(input logic [6:0] op, input logic hold_on_jump);
    return op == OP_BRANCH || (hold_on_jump && (op == OP_JAL || op == OP_JALR));
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous prefetch queue with push/pop/flush.
// Ports: clk, rst_n (sync, active-low), push/push_data, pop, flush, head (oldest entry, 0 when empty), count.
module fetch_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign do_push = rst_n && push && !flush && count < CW'(DEPTH);
  assign do_pop = pop && count != '0;
  assign head = count != '0 ? mem[rd] : '0;
  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: prefetching instruction-fetch front end that holds on control transfers until redirected.
// Ports: memory side mem_req/mem_addr/mem_ready/mem_rvalid/mem_rdata; redirect/redirect_pc from execute;
// decoder side out_valid/out_ready/out_instr/out_pc; status holding and q_count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit HOLD_ON_JUMP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     mem_req,
  output logic [XLEN-1:0]          mem_addr,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [ILEN-1:0]          mem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic                     holding,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state, state_nx;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic drop, live, resp, ctl, accept, busy_nx, push;
  logic [ILEN+XLEN-1:0] head;
  assign resp = state == WAIT && mem_rvalid;
  assign ctl = is_ctl(mem_rdata[6:0], HOLD_ON_JUMP);
  assign accept = mem_req && mem_ready;
  // a request is still in flight after this edge if one is accepted now or the current one has not returned
  assign busy_nx = accept || (state == WAIT && !mem_rvalid);
  assign push = resp && !drop && !redirect;
  assign mem_addr = fetch_pc;
  assign out_valid = q_count != '0;
  assign {out_instr, out_pc} = head;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = redirect ? (busy_nx ? WAIT : IDLE) : accept ? WAIT : resp ? ((drop || !ctl) ? IDLE : HOLD) : state;
  end
  // live keeps mem_req low for the first cycle after reset is released
  always_comb begin
    mem_req = live && (state == IDLE || (resp && !drop && !ctl)) && (q_count + CW'(state == WAIT)) < CW'(DEPTH);
    holding = state == HOLD;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc <= '0;
      drop <= 1'b0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (accept) req_pc <= fetch_pc;
      fetch_pc <= redirect ? (redirect_pc & ~XLEN'(3)) : accept ? fetch_pc + XLEN'(4) : fetch_pc;
      drop <= redirect ? busy_nx : resp ? 1'b0 : drop;
    end
  end
  fetch_fifo #(.W(ILEN + XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .push_data({mem_rdata, req_pc}),
    .pop(out_valid && out_ready),
    .flush(redirect),
    .head(head),
    .count(q_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed scoreboard bench for fetch_unit against a transaction-level program model
`timescale 1ns/1ns
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam bit HOJ = 1'b1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_req, mem_ready = 1'b0, mem_rvalid = 1'b0, redirect = 1'b0;
  logic out_valid, out_ready = 1'b0, holding;
  logic [31:0] mem_addr, mem_rdata = '0, redirect_pc = '0, out_instr, out_pc;
  logic [2:0] q_count;
  fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .HOLD_ON_JUMP(HOJ)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .holding(holding), .q_count(q_count)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, n_pops = 0;
  int k_ready = 100, k_mready = 100, k_redir = 0, k_spur = 0, k_lat = 1;
  bit k_mix = 1'b0, f_redir = 1'b0, run = 1'b0;
  logic [31:0] f_tgt = '0;
  logic live = 1'b0;
  logic [31:0] ovr [logic [31:0]];
  logic [63:0] sb [$];
  logic [31:0] f_pc = '0, p_addr = '0;
  bit blocked = 1'b0, pend = 1'b0, p_drop = 1'b0;
  int p_cnt = 0;
  always @(posedge clk) live <= rst_n;
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] h;
    if (ovr.exists(a)) return ovr[a];
    h = (a ^ 32'h5bd1e995) * 32'h9e3779b1;
    if (!k_mix || h[31:28] > 4'd2) return {h[31:7], 7'b0010011};
    return {h[31:7], h[29:28] == 2'd0 ? 7'b1100011 : h[29:28] == 2'd1 ? 7'b1101111 : 7'b1100111};
  endfunction
  function automatic bit is_ct(input logic [31:0] i);
    return i[6:0] == 7'h63 || (HOJ && (i[6:0] == 7'h6f || i[6:0] == 7'h67));
  endfunction
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask
  initial begin
    bit arr, acc, exp_req;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      arr = 1'b0;
      if (pend && p_cnt == 1) begin
        arr = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = imem(p_addr);
      end else begin
        if (pend) p_cnt--;
        mem_rvalid = !pend && ($urandom_range(99) < k_spur);
        mem_rdata = $urandom;
      end
      out_ready = $urandom_range(99) < k_ready;
      redirect = f_redir || ($urandom_range(99) < (blocked ? 5 * k_redir : k_redir));
      redirect_pc = f_redir ? f_tgt : ($urandom_range(9) == 0 ? 32'hffff_fff0 | 32'($urandom_range(3)) : 32'($urandom_range(1023)));
      f_redir = 1'b0;
      mem_ready = $urandom_range(99) < k_mready;
      #1;
      exp_req = live && !blocked && (!pend || (arr && !p_drop && !is_ct(mem_rdata))) && (sb.size() + int'(pend)) < DEPTH;
      if (run) begin
        chk("mem_req", mem_req, exp_req);
        if (mem_req) chk("mem_addr", mem_addr, f_pc);
      end
      acc = exp_req && mem_ready;
      got = mem_rdata;
      #2;
      if (!rst_n) begin
        sb.delete();
        pend = 1'b0;
        p_drop = 1'b0;
        blocked = 1'b0;
        f_pc = '0;
      end else begin
        if (arr) begin
          pend = 1'b0;
          if (!p_drop && !redirect) begin
            sb.push_back({p_addr, got});
            if (is_ct(got)) blocked = 1'b1;
          end
        end
        if (acc) begin
          pend = 1'b1;
          p_addr = f_pc;
          p_cnt = k_lat == 0 ? int'($urandom_range(3, 1)) : k_lat;
          p_drop = 1'b0;
          f_pc += 4;
        end
        if (redirect) begin
          sb.delete();
          f_pc = redirect_pc & ~32'h3;
          blocked = 1'b0;
          p_drop = pend;
        end
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (run) begin
        chk("q_count", q_count, sb.size());
        chk("holding", holding, blocked);
        chk("out_valid", out_valid, sb.size() != 0);
        if (sb.size() != 0) begin
          chk("head", {out_pc, out_instr}, sb[0]);
          if (out_ready) begin
            void'(sb.pop_front());
            n_pops++;
          end
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int np;
    step(3);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_hold", holding, 0);
    chk("rst_count", q_count, 0);
    rst_n = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (c < 5) begin
        chk("A_req", mem_req, 1);
        chk("A_addr", mem_addr, 4 * c);
      end
      if (c == 1) chk("A_fill", out_valid, 0);
      if (c >= 2) begin
        chk("A_valid", out_valid, 1);
        chk("A_pc", out_pc, 4 * (c - 2));
      end
    end
    k_ready = 0;
    reset_dut();
    for (int c = 0; c < 11; c++) begin
      step(1);
      if (c == 8) begin
        chk("B_full", q_count, 4);
        chk("B_noreq", mem_req, 0);
        chk("B_head", out_pc, 0);
        k_ready = 100;
      end
      if (c == 9) chk("B_still", mem_req, 0);
      if (c == 10) begin
        chk("B_resume", mem_req, 1);
        chk("B_addr", mem_addr, 32'h10);
      end
    end
    ovr[32'h8] = 32'h0000_0063;
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (c == 3) chk("C_stop", mem_req, 0);
      if (c == 6) begin
        chk("C_hold", holding, 1);
        chk("C_noreq", mem_req, 0);
        chk("C_drained", q_count, 0);
        f_tgt = 32'h43;
        f_redir = 1'b1;
      end
      if (c == 8) begin
        chk("C_req", mem_req, 1);
        chk("C_addr", mem_addr, 32'h40);
        chk("C_unhold", holding, 0);
      end
    end
    ovr.delete();
    k_lat = 3;
    reset_dut();
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (c == 4) begin
        f_tgt = 32'h100;
        f_redir = 1'b1;
      end
      if (c == 6) begin
        chk("D_drop_req", mem_req, 0);
        chk("D_count", q_count, 0);
      end
      if (c == 7) begin
        chk("D_req", mem_req, 1);
        chk("D_addr", mem_addr, 32'h100);
      end
      if (c == 11) begin
        chk("D_valid", out_valid, 1);
        chk("D_pc", out_pc, 32'h100);
      end
    end
    k_lat = 1;
    ovr[32'h0] = 32'h0000_006f;
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (c == 1) chk("E_stop", mem_req, 0);
      if (c == 2) begin
        chk("E_hold", holding, 1);
        chk("E_noreq", mem_req, 0);
      end
    end
    ovr.delete();
    k_ready = 0;
    reset_dut();
    np = 0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      if (c == 8) begin
        np = n_pops;
        k_ready = 100;
        f_tgt = 32'h200;
        f_redir = 1'b1;
      end
      if (c == 10) begin
        chk("F_valid", out_valid, 0);
        chk("F_count", q_count, 0);
        chk("F_once", n_pops - np, 1);
      end
    end
    k_mix = 1'b1;
    k_lat = 0;
    k_ready = 70;
    k_mready = 70;
    k_redir = 4;
    k_spur = 20;
    np = n_pops;
    for (int r = 0; r < 3; r++) begin
      reset_dut();
      step(1000);
    end
    chk("G_progress", n_pops > np + 100, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
